reorder_buffer: RTL and testbench

Circular in-order retirement buffer for the Tomasulo core. It sits between the dispatcher, which allocates entries, and the architectural register file. It absorbs out-of-order writebacks from the CDB and retires one entry per cycle in program order. On retirement it drives the register-file write port (enable/addr/data). On a mispredicted branch it flushes everything and issues a PC redirect.

---
 rtl/reorder_buffer.sv | 122 ++++++++++++
 tb/tb_reorder_buffer.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reorder_buffer.sv
// rtl/reorder_buffer.sv - circular in-order retirement buffer with CDB writeback,
// operand query bypass and mispredict flush/redirect
module reorder_buffer #(
    parameter int ROB_ADDR_W = 4,
    parameter int DATA_W     = 32,
    parameter int REG_W      = 5
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    input  logic                  alloc_valid_in,
    input  logic [REG_W-1:0]      alloc_rd_in,
    input  logic                  alloc_is_branch_in,
    input  logic                  alloc_pred_taken_in,
    input  logic [DATA_W-1:0]     alloc_alt_pc_in,
    output logic [ROB_ADDR_W-1:0] alloc_tag_out,
    output logic                  full_out,
    input  logic                  wb_valid_in,
    input  logic [ROB_ADDR_W-1:0] wb_tag_in,
    input  logic [DATA_W-1:0]     wb_data_in,
    input  logic                  wb_taken_in,
    input  logic [ROB_ADDR_W-1:0] qry_tag_in,
    output logic                  qry_ready_out,
    output logic [DATA_W-1:0]     qry_data_out,
    output logic                  commit_enable_out,
    output logic [REG_W-1:0]      commit_addr_out,
    output logic [DATA_W-1:0]     commit_data_out,
    output logic [ROB_ADDR_W-1:0] commit_tag_out,
    output logic                  flush_out,
    output logic [DATA_W-1:0]     redirect_pc_out
);
    localparam int DEPTH = 1 << ROB_ADDR_W;
    localparam logic [ROB_ADDR_W:0] DEPTH_CNT = (ROB_ADDR_W+1)'(DEPTH);

    logic [ROB_ADDR_W-1:0] head, tail;
    logic [ROB_ADDR_W:0]   count;

    logic [DEPTH-1:0]  ent_valid, ent_ready, ent_branch, ent_pred, ent_taken;
    logic [REG_W-1:0]  ent_rd     [DEPTH];
    logic [DATA_W-1:0] ent_alt_pc [DEPTH];
    logic [DATA_W-1:0] ent_data   [DEPTH];

    logic alloc_ok, wb_hit, commit_do, mispredict;

    assign full_out      = (count == DEPTH_CNT);
    assign alloc_tag_out = tail;

    // full_out comes from the registered count, so a same-edge commit never frees a slot early
    assign alloc_ok   = alloc_valid_in & ~full_out & ~flush_out;
    assign wb_hit     = wb_valid_in & ent_valid[wb_tag_in];
    assign commit_do  = ent_valid[head] & ent_ready[head];
    assign mispredict = commit_do & ent_branch[head] & (ent_taken[head] != ent_pred[head]);

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            head              <= '0;
            tail              <= '0;
            count             <= '0;
            ent_valid         <= '0;
            ent_ready         <= '0;
            commit_enable_out <= 1'b0;
            commit_addr_out   <= '0;
            commit_data_out   <= '0;
            commit_tag_out    <= '0;
            flush_out         <= 1'b0;
            redirect_pc_out   <= '0;
        end else if (!rdy_in) begin
            commit_enable_out <= 1'b0;
            flush_out         <= 1'b0;
        end else begin
            commit_enable_out <= commit_do && (ent_rd[head] != '0);
            if (commit_do) begin
                commit_addr_out <= ent_rd[head];
                commit_data_out <= ent_data[head];
                commit_tag_out  <= head;
            end
            flush_out <= mispredict;
            if (mispredict) begin
                redirect_pc_out <= ent_alt_pc[head];
                ent_valid       <= '0;
                head            <= '0;
                tail            <= '0;
                count           <= '0;
            end else begin
                if (wb_hit) begin
                    ent_ready[wb_tag_in] <= 1'b1;
                    ent_data[wb_tag_in]  <= wb_data_in;
                    ent_taken[wb_tag_in] <= wb_taken_in;
                end
                if (alloc_ok) begin
                    ent_valid[tail]  <= 1'b1;
                    ent_ready[tail]  <= 1'b0;
                    ent_rd[tail]     <= alloc_rd_in;
                    ent_branch[tail] <= alloc_is_branch_in;
                    ent_pred[tail]   <= alloc_pred_taken_in;
                    ent_alt_pc[tail] <= alloc_alt_pc_in;
                    tail             <= tail + ROB_ADDR_W'(1);
                end
                if (commit_do) begin
                    ent_valid[head] <= 1'b0;
                    head            <= head + ROB_ADDR_W'(1);
                end
                count <= count + (ROB_ADDR_W+1)'(alloc_ok) - (ROB_ADDR_W+1)'(commit_do);
            end
        end
    end

    // Operand lookup: a same-cycle CDB result for a live entry wins over the stored copy
    always_comb begin
        qry_ready_out = 1'b0;
        qry_data_out  = '0;
        if (ent_valid[qry_tag_in]) begin
            if (wb_valid_in && (wb_tag_in == qry_tag_in)) begin
                qry_ready_out = 1'b1;
                qry_data_out  = wb_data_in;
            end else if (ent_ready[qry_tag_in]) begin
                qry_ready_out = 1'b1;
                qry_data_out  = ent_data[qry_tag_in];
            end
        end
    end
endmodule

// File: tb/tb_reorder_buffer.sv
// tb/tb_reorder_buffer.sv - scoreboard bench for reorder_buffer with a program-order
// retirement model, directed corner cases and a randomized phase
module tb_reorder_buffer;
    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in;
    logic        alloc_valid_in, alloc_is_branch_in, alloc_pred_taken_in;
    logic [4:0]  alloc_rd_in;
    logic [31:0] alloc_alt_pc_in;
    logic [3:0]  alloc_tag_out;
    logic        full_out;
    logic        wb_valid_in, wb_taken_in;
    logic [3:0]  wb_tag_in, qry_tag_in;
    logic [31:0] wb_data_in;
    logic        qry_ready_out;
    logic [31:0] qry_data_out;
    logic        commit_enable_out, flush_out;
    logic [4:0]  commit_addr_out;
    logic [31:0] commit_data_out, redirect_pc_out;
    logic [3:0]  commit_tag_out;

    reorder_buffer dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .alloc_valid_in(alloc_valid_in), .alloc_rd_in(alloc_rd_in),
        .alloc_is_branch_in(alloc_is_branch_in), .alloc_pred_taken_in(alloc_pred_taken_in),
        .alloc_alt_pc_in(alloc_alt_pc_in), .alloc_tag_out(alloc_tag_out), .full_out(full_out),
        .wb_valid_in(wb_valid_in), .wb_tag_in(wb_tag_in), .wb_data_in(wb_data_in),
        .wb_taken_in(wb_taken_in), .qry_tag_in(qry_tag_in), .qry_ready_out(qry_ready_out),
        .qry_data_out(qry_data_out), .commit_enable_out(commit_enable_out),
        .commit_addr_out(commit_addr_out), .commit_data_out(commit_data_out),
        .commit_tag_out(commit_tag_out), .flush_out(flush_out), .redirect_pc_out(redirect_pc_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [3:0]  tag;
        logic [4:0]  rd;
        bit          br, pred, done, taken;
        logic [31:0] alt, data;
    } ent_t;
    typedef struct {
        bit          is_flush;
        logic [4:0]  addr;
        logic [31:0] data;
        logic [3:0]  tag;
    } exp_t;

    ent_t m_q[$];
    exp_t exp_q[$];
    logic [3:0] m_tag;
    bit flush_pending, flush_seen;
    int n_checks = 0, n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Retirement in program order: an entry retires once it and everything older has a result
    task automatic model_retire();
        ent_t e;
        exp_t x;
        while (m_q.size() > 0 && m_q[0].done) begin
            e = m_q.pop_front();
            if (e.rd != 5'd0) begin
                x.is_flush = 1'b0; x.addr = e.rd; x.data = e.data; x.tag = e.tag;
                exp_q.push_back(x);
            end
            if (e.br && (e.taken != e.pred)) begin
                x.is_flush = 1'b1; x.addr = '0; x.data = e.alt; x.tag = e.tag;
                exp_q.push_back(x);
                m_q.delete();
                m_tag = 4'd0;
                flush_pending = 1'b1;
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk_in);
        #1;
        alloc_valid_in = 1'b0;
        wb_valid_in    = 1'b0;
    endtask

    task automatic do_alloc(input logic [4:0] rd, input bit br, input bit pred, input logic [31:0] alt);
        ent_t e;
        chk("alloc_not_full", 32'(full_out), 32'd0);
        chk("alloc_tag", 32'(alloc_tag_out), 32'(m_tag));
        alloc_valid_in = 1'b1; alloc_rd_in = rd; alloc_is_branch_in = br;
        alloc_pred_taken_in = pred; alloc_alt_pc_in = alt;
        e.tag = m_tag; e.rd = rd; e.br = br; e.pred = pred; e.alt = alt;
        e.done = 1'b0; e.taken = 1'b0; e.data = '0;
        m_q.push_back(e);
        m_tag = m_tag + 4'd1;
    endtask

    task automatic do_wb(input logic [3:0] tag, input logic [31:0] data, input bit taken);
        ent_t e;
        wb_valid_in = 1'b1; wb_tag_in = tag; wb_data_in = data; wb_taken_in = taken;
        foreach (m_q[i]) begin
            if (m_q[i].tag == tag && !m_q[i].done) begin
                e = m_q[i]; e.done = 1'b1; e.data = data; e.taken = taken; m_q[i] = e;
            end
        end
        model_retire();
    endtask

    task automatic wait_flush();
        int n = 0;
        rdy_in = 1'b1;
        while (!flush_seen && n < 60) begin
            cycle();
            n++;
        end
        n_checks++;
        if (!flush_seen) begin
            n_fail++;
            $display("FAIL flush_timeout: no flush pulse within %0d cycles", n);
        end
        flush_seen = 1'b0;
        flush_pending = 1'b0;
    endtask

    task automatic drain(input int tail_cycles);
        int n = 0;
        while (exp_q.size() != 0 && n < 150) begin
            cycle();
            n++;
        end
        repeat (tail_cycles) cycle();
        chk("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic do_reset();
        rst_in = 1'b1; alloc_valid_in = 1'b0; wb_valid_in = 1'b0;
        cycle();
        exp_q.delete(); m_q.delete(); m_tag = 4'd0;
        flush_pending = 1'b0; flush_seen = 1'b0;
        qry_tag_in = 4'd0;
        #1;
        chk("rst_commit_en", 32'(commit_enable_out), 32'd0);
        chk("rst_commit_addr", 32'(commit_addr_out), 32'd0);
        chk("rst_commit_data", commit_data_out, 32'd0);
        chk("rst_commit_tag", 32'(commit_tag_out), 32'd0);
        chk("rst_flush", 32'(flush_out), 32'd0);
        chk("rst_redirect", redirect_pc_out, 32'd0);
        chk("rst_full", 32'(full_out), 32'd0);
        chk("rst_alloc_tag", 32'(alloc_tag_out), 32'd0);
        chk("rst_qry_ready", 32'(qry_ready_out), 32'd0);
        rst_in = 1'b0;
        rdy_in = 1'b1;
    endtask

    // Monitor: every visible retirement or flush must match the head of the scoreboard
    always @(negedge clk_in) begin
        exp_t x;
        if (commit_enable_out === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_commit: tag %0d addr %0d with nothing expected", commit_tag_out, commit_addr_out);
            end else begin
                x = exp_q.pop_front();
                if (x.is_flush) begin
                    n_fail++;
                    $display("FAIL commit_order: got commit tag %0d expected flush", commit_tag_out);
                end else begin
                    chk("commit_addr", 32'(commit_addr_out), 32'(x.addr));
                    chk("commit_data", commit_data_out, x.data);
                    chk("commit_tag", 32'(commit_tag_out), 32'(x.tag));
                end
            end
        end
        if (flush_out === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0 || !exp_q[0].is_flush) begin
                n_fail++;
                $display("FAIL unexpected_flush: redirect %0h with no flush expected", redirect_pc_out);
            end else begin
                x = exp_q.pop_front();
                chk("redirect_pc", redirect_pc_out, x.data);
                flush_seen = 1'b1;
            end
        end
    end

    initial begin
        int cand[$];
        int idx;
        bit do_w, w_taken, br;
        logic [3:0] w_tag, t;
        rst_in = 1'b1; rdy_in = 1'b1;
        alloc_valid_in = 1'b0; alloc_rd_in = '0; alloc_is_branch_in = 1'b0;
        alloc_pred_taken_in = 1'b0; alloc_alt_pc_in = '0;
        wb_valid_in = 1'b0; wb_tag_in = '0; wb_data_in = '0; wb_taken_in = 1'b0;
        qry_tag_in = '0; flush_pending = 1'b0; flush_seen = 1'b0; m_tag = '0;
        do_reset();

        // Out-of-order writebacks retire in program order
        for (int i = 0; i < 3; i++) begin do_alloc(5'(i + 1), 1'b0, 1'b0, 32'd0); cycle(); end
        do_wb(4'd2, 32'hA, 1'b0); cycle();
        do_wb(4'd1, 32'hB, 1'b0); cycle();
        do_wb(4'd0, 32'hC, 1'b0); cycle();
        chk("no_same_edge_commit", 32'(commit_enable_out), 32'd0);
        cycle();
        chk("commit_latency", 32'(commit_enable_out), 32'd1);
        chk("first_commit_tag", 32'(commit_tag_out), 32'd0);
        drain(3);

        // Fill to 16, reject the 17th, reject an alloc at the freeing commit edge, then wrap
        do_reset();
        for (int i = 0; i < 16; i++) begin do_alloc(5'(i + 1), 1'b0, 1'b0, 32'd0); cycle(); end
        chk("full_after_16", 32'(full_out), 32'd1);
        chk("tail_wrapped", 32'(alloc_tag_out), 32'd0);
        alloc_valid_in = 1'b1; alloc_rd_in = 5'd20; cycle();
        chk("full_holds", 32'(full_out), 32'd1);
        chk("tail_stays", 32'(alloc_tag_out), 32'd0);
        do_wb(4'd0, 32'h1234, 1'b0); cycle();
        chk("full_before_commit", 32'(full_out), 32'd1);
        alloc_valid_in = 1'b1; cycle();
        chk("full_drops", 32'(full_out), 32'd0);
        chk("alloc_rejected_at_commit", 32'(alloc_tag_out), 32'd0);
        do_alloc(5'd21, 1'b0, 1'b0, 32'd0); cycle();
        for (int i = 1; i < 16; i++) begin do_wb(4'(i), $urandom, 1'b0); cycle(); end
        do_wb(4'd0, 32'hBEEF, 1'b0); cycle();
        drain(3);

        // x0 destination retires without a register-file write
        t = m_tag;
        do_alloc(5'd0, 1'b0, 1'b0, 32'd0); cycle();
        do_wb(t, 32'h55, 1'b0); cycle();
        cycle();
        chk("x0_no_write", 32'(commit_enable_out), 32'd0);
        qry_tag_in = t; #1;
        chk("x0_retired", 32'(qry_ready_out), 32'd0);
        chk("x0_tail", 32'(alloc_tag_out), 32'(4'(t + 4'd1)));
        do_alloc(5'd7, 1'b0, 1'b0, 32'd0); cycle();
        do_wb(4'(t + 4'd1), 32'h66, 1'b0); cycle();
        drain(3);

        // Mispredicted branch flushes two younger, already-completed entries
        t = m_tag;
        do_alloc(5'd0, 1'b1, 1'b0, 32'h100); cycle();
        do_alloc(5'd9, 1'b0, 1'b0, 32'd0); cycle();
        do_alloc(5'd10, 1'b0, 1'b0, 32'd0); cycle();
        do_wb(4'(t + 4'd1), 32'h91, 1'b0); cycle();
        do_wb(4'(t + 4'd2), 32'h92, 1'b0); cycle();
        do_wb(t, 32'd0, 1'b1); cycle();
        wait_flush();
        chk("flush_cleared", 32'(flush_out), 32'd0);
        chk("flush_full", 32'(full_out), 32'd0);
        chk("flush_tail", 32'(alloc_tag_out), 32'd0);
        chk("redirect_holds", redirect_pc_out, 32'h100);
        drain(5);

        // Query bypass, stored result, unallocated and not-ready tags
        for (int i = 0; i < 4; i++) begin do_alloc(5'(i + 1), 1'b0, 1'b0, 32'd0); cycle(); end
        do_wb(4'd3, 32'h77, 1'b0);
        qry_tag_in = 4'd3; #1;
        chk("qry_bypass_ready", 32'(qry_ready_out), 32'd1);
        chk("qry_bypass_data", qry_data_out, 32'h77);
        qry_tag_in = 4'd9; #1;
        chk("qry_unalloc_ready", 32'(qry_ready_out), 32'd0);
        chk("qry_unalloc_data", qry_data_out, 32'd0);
        cycle();
        qry_tag_in = 4'd3; #1;
        chk("qry_stored_ready", 32'(qry_ready_out), 32'd1);
        chk("qry_stored_data", qry_data_out, 32'h77);
        qry_tag_in = 4'd2; #1;
        chk("qry_not_ready", 32'(qry_ready_out), 32'd0);
        wb_valid_in = 1'b1; wb_tag_in = 4'd9; wb_data_in = 32'hDEAD; qry_tag_in = 4'd9; #1;
        chk("qry_bypass_needs_valid", 32'(qry_ready_out), 32'd0);
        cycle();
        #1;
        chk("wb_invalid_ignored", 32'(qry_ready_out), 32'd0);
        for (int i = 0; i < 3; i++) begin do_wb(4'(i), 32'h300 + 32'(i), 1'b0); cycle(); end
        drain(3);

        // Freeze with a ready head: nothing moves until rdy_in returns
        t = m_tag;
        do_alloc(5'd5, 1'b0, 1'b0, 32'd0); cycle();
        do_wb(t, 32'h5A5A, 1'b0); cycle();
        rdy_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            alloc_valid_in = 1'b1;
            cycle();
            chk("frozen_no_commit", 32'(commit_enable_out), 32'd0);
        end
        chk("frozen_tail", 32'(alloc_tag_out), 32'(4'(t + 4'd1)));
        qry_tag_in = t; #1;
        chk("frozen_head_valid", 32'(qry_ready_out), 32'd1);
        rdy_in = 1'b1;
        cycle();
        chk("resume_commit", 32'(commit_enable_out), 32'd1);
        chk("resume_tag", 32'(commit_tag_out), 32'(t));
        drain(3);

        // Reset mid-stream while commits are in flight, with rdy_in low
        t = m_tag;
        for (int i = 0; i < 4; i++) begin do_alloc(5'(11 + i), 1'b0, 1'b0, 32'd0); cycle(); end
        for (int i = 0; i < 4; i++) begin do_wb(4'(t + 4'(i)), $urandom, 1'b0); cycle(); end
        rdy_in = 1'b0;
        do_reset();

        // Randomized traffic with correct and mispredicted branches
        for (int c = 0; c < 800; c++) begin
            rdy_in = ($urandom_range(0, 9) != 0);
            if (rdy_in) begin
                cand.delete();
                foreach (m_q[i]) if (!m_q[i].done) cand.push_back(i);
                do_w = (cand.size() > 0) && ($urandom_range(0, 1) == 1);
                if (do_w) begin
                    idx = cand[$urandom_range(0, cand.size() - 1)];
                    w_tag = m_q[idx].tag;
                    if (m_q[idx].br)
                        w_taken = ($urandom_range(0, 2) == 0) ? ~m_q[idx].pred : m_q[idx].pred;
                    else
                        w_taken = 1'($urandom_range(0, 1));
                end
                if (m_q.size() < 6 && $urandom_range(0, 1) == 1) begin
                    br = ($urandom_range(0, 4) == 0);
                    do_alloc(5'($urandom_range(0, 31)), br, 1'($urandom_range(0, 1)), $urandom);
                end
                if (do_w) do_wb(w_tag, $urandom, w_taken);
            end
            cycle();
            if (flush_pending) wait_flush();
        end
        rdy_in = 1'b1;
        drain(20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
